shared_adder_arbiter: RTL and testbench

//  Time-shares one registered N-bit adder between three requesters. These would

---
 rtl/shared_adder_arbiter_if.sv | 26 ++
 rtl/shared_adder_arbiter.sv | 157 +++++++++++++++
 tb/tb_shared_adder_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/shared_adder_arbiter_if.sv
// Requester/consumer-facing signal bundle of the shared adder arbiter.
// The master modport belongs to the requesters and consumer, and the slave modport belongs to the arbiter.
interface shared_adder_arbiter_if #(
  parameter int N = 4
);
  logic [2:0]     req;
  logic [3*N-1:0] a_bus;
  logic [3*N-1:0] b_bus;
  logic [2:0]     gnt;
  logic           busy;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [N:0]     rsp_sum;
  logic [15:0]    op_count;

  modport master (
    output req, a_bus, b_bus, rsp_ready,
    input  gnt, busy, rsp_valid, rsp_id, rsp_sum, op_count
  );

  modport slave (
    input  req, a_bus, b_bus, rsp_ready,
    output gnt, busy, rsp_valid, rsp_id, rsp_sum, op_count
  );
endinterface

// File: rtl/shared_adder_arbiter.sv
// One registered N-bit adder time-shared by three requesters.
// The requesters are arbitrated round-robin, and each result is returned on a valid/ready response port.
module shared_adder_arbiter #(
  parameter int N    = 4,
  parameter int NREQ = 3
) (
  input logic                clk,
  input logic                rst_n,
  shared_adder_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [N-1:0]    a_q_r, a_q_nxt_s;
  logic [N-1:0]    b_q_r, b_q_nxt_s;
  logic [1:0]      id_q_r, id_q_nxt_s;
  logic [1:0]      last_id_r, last_id_nxt_s;
  logic [NREQ-1:0] gnt_r, gnt_nxt_s;
  logic            busy_r;
  logic            rsp_valid_r, rsp_valid_nxt_s;
  logic [1:0]      rsp_id_r, rsp_id_nxt_s;
  logic [N:0]      rsp_sum_r, rsp_sum_nxt_s;
  logic [15:0]     op_count_r, op_count_nxt_s;
  logic [1:0]      win_s;

  // Search starts just after the last served requester; later hits are overwritten by earlier ones.
  function automatic logic [1:0] pick_winner(input logic [2:0] req_v, input logic [1:0] last);
    logic [1:0] win;
    logic [1:0] idx;
    win = 2'd0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = 2'((32'(last) + 32'(k)) % 32'(NREQ));
      if (req_v[idx]) begin
        win = idx;
      end else begin
        win = win;
      end
    end
    return win;
  endfunction

  assign win_s = pick_winner(bus.req, last_id_r);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.req != 3'b000) begin
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: state_nxt_s = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and captured operands.
  always_comb begin
    a_q_nxt_s       = a_q_r;
    b_q_nxt_s       = b_q_r;
    id_q_nxt_s      = id_q_r;
    last_id_nxt_s   = last_id_r;
    gnt_nxt_s       = {NREQ{1'b0}};
    rsp_valid_nxt_s = rsp_valid_r;
    rsp_id_nxt_s    = rsp_id_r;
    rsp_sum_nxt_s   = rsp_sum_r;
    op_count_nxt_s  = op_count_r;
    case (state_r)
      IDLE: begin
        if (bus.req != 3'b000) begin
          a_q_nxt_s  = bus.a_bus[32'(win_s)*N +: N];
          b_q_nxt_s  = bus.b_bus[32'(win_s)*N +: N];
          id_q_nxt_s = win_s;
          gnt_nxt_s  = NREQ'(3'b001 << win_s);
        end else begin
          gnt_nxt_s  = {NREQ{1'b0}};
        end
      end
      CALC: begin
        rsp_sum_nxt_s   = {1'b0, a_q_r} + {1'b0, b_q_r};
        rsp_id_nxt_s    = id_q_r;
        rsp_valid_nxt_s = 1'b1;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_nxt_s = 1'b0;
          last_id_nxt_s   = id_q_r;
          op_count_nxt_s  = op_count_r + 16'd1;
        end else begin
          rsp_valid_nxt_s = 1'b1;
        end
      end
      default: begin
        rsp_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; an async reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q_r       <= {N{1'b0}};
      b_q_r       <= {N{1'b0}};
      id_q_r      <= 2'd0;
      last_id_r   <= 2'd2;
      gnt_r       <= {NREQ{1'b0}};
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 2'd0;
      rsp_sum_r   <= {(N+1){1'b0}};
      op_count_r  <= 16'd0;
    end else begin
      a_q_r       <= a_q_nxt_s;
      b_q_r       <= b_q_nxt_s;
      id_q_r      <= id_q_nxt_s;
      last_id_r   <= last_id_nxt_s;
      gnt_r       <= gnt_nxt_s;
      busy_r      <= (state_nxt_s != IDLE);
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_id_r    <= rsp_id_nxt_s;
      rsp_sum_r   <= rsp_sum_nxt_s;
      op_count_r  <= op_count_nxt_s;
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.busy      = busy_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_sum   = rsp_sum_r;
  assign bus.op_count  = op_count_r;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Directed and randomized transactions against a transaction-level round-robin adder model.
module tb_shared_adder_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   last_m;
  int   cnt_m;

  shared_adder_arbiter_if #(.N(4)) bus_if();

  shared_adder_arbiter #(.N(4), .NREQ(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first set requester after the last served one, wrapping modulo 3.
  function automatic int rr_pick(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++) begin
      if (r[(last + k) % 3]) return (last + k) % 3;
    end
    return 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(bus_if.gnt), 32'd0);
    chk({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
    chk({tag, "_valid"}, 32'(bus_if.rsp_valid), 32'd0);
    chk({tag, "_id"}, 32'(bus_if.rsp_id), 32'd0);
    chk({tag, "_sum"}, 32'(bus_if.rsp_sum), 32'd0);
    chk({tag, "_cnt"}, 32'(bus_if.op_count), 32'd0);
  endtask

  task automatic do_txn(input logic [2:0] r, input logic [11:0] a, input logic [11:0] b,
                        input int delay);
    int w;
    int es;
    w  = rr_pick(r, last_m);
    es = int'(a[w*4 +: 4]) + int'(b[w*4 +: 4]);
    bus_if.req       = r;
    bus_if.a_bus     = a;
    bus_if.b_bus     = b;
    bus_if.rsp_ready = 1'b0;
    @(posedge clk); #1;
    chk("gnt", 32'(bus_if.gnt), 32'(1 << w));
    chk("busy_calc", 32'(bus_if.busy), 32'd1);
    chk("valid_calc", 32'(bus_if.rsp_valid), 32'd0);
    bus_if.req       = 3'b000;
    bus_if.a_bus     = ~a;
    bus_if.b_bus     = 12'($urandom);
    bus_if.rsp_ready = (delay == 0);
    @(posedge clk); #1;
    chk("valid_resp", 32'(bus_if.rsp_valid), 32'd1);
    chk("rsp_id", 32'(bus_if.rsp_id), 32'(w));
    chk("rsp_sum", 32'(bus_if.rsp_sum), 32'(es));
    chk("gnt_resp", 32'(bus_if.gnt), 32'd0);
    for (int i = 0; i < delay; i++) begin
      bus_if.req = 3'($urandom_range(1, 7));
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus_if.rsp_valid), 32'd1);
      chk("hold_id", 32'(bus_if.rsp_id), 32'(w));
      chk("hold_sum", 32'(bus_if.rsp_sum), 32'(es));
      chk("hold_gnt", 32'(bus_if.gnt), 32'd0);
      chk("hold_busy", 32'(bus_if.busy), 32'd1);
      if (i == delay - 1) bus_if.rsp_ready = 1'b1;
    end
    bus_if.req = 3'b000;
    @(posedge clk); #1;
    cnt_m  = (cnt_m + 1) % 65536;
    last_m = w;
    chk("done_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("done_busy", 32'(bus_if.busy), 32'd0);
    chk("op_count", 32'(bus_if.op_count), 32'(cnt_m));
    bus_if.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] ha;
    logic [11:0] hb;
    int w;
    n_checks = 0;
    n_fail   = 0;
    last_m   = 2;
    cnt_m    = 0;
    clk      = 1'b0;
    rst_n    = 1'b0;
    bus_if.req       = 3'b000;
    bus_if.a_bus     = 12'd0;
    bus_if.b_bus     = 12'd0;
    bus_if.rsp_ready = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Held req=111 with ready high: rotation 0,1,2,0 and a grant every 3 cycles.
    ha = 12'($urandom);
    hb = 12'($urandom);
    bus_if.req       = 3'b111;
    bus_if.a_bus     = ha;
    bus_if.b_bus     = hb;
    bus_if.rsp_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      w = rr_pick(3'b111, last_m);
      @(posedge clk); #1;
      chk("rr_gnt", 32'(bus_if.gnt), 32'(1 << w));
      @(posedge clk); #1;
      chk("rr_id", 32'(bus_if.rsp_id), 32'(w));
      chk("rr_sum", 32'(bus_if.rsp_sum), 32'(int'(ha[w*4 +: 4]) + int'(hb[w*4 +: 4])));
      @(posedge clk); #1;
      cnt_m  = cnt_m + 1;
      last_m = w;
      chk("rr_valid_off", 32'(bus_if.rsp_valid), 32'd0);
      chk("rr_cnt", 32'(bus_if.op_count), 32'(cnt_m));
    end
    bus_if.req       = 3'b000;
    bus_if.rsp_ready = 1'b0;

    do_txn(3'b001, {8'($urandom), 4'd3}, {8'($urandom), 4'd5}, 0);
    do_txn(3'b100, {4'd15, 8'($urandom)}, {4'd15, 8'($urandom)}, 0);
    do_txn(3'b011, 12'($urandom), 12'($urandom), 5);

    for (int t = 0; t < 24; t++) begin
      do_txn(3'($urandom_range(1, 7)), 12'($urandom), 12'($urandom), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        chk("idle_busy", 32'(bus_if.busy), 32'd0);
        chk("idle_gnt", 32'(bus_if.gnt), 32'd0);
      end
    end

    // Async reset while a result waits in RESP.
    bus_if.req   = 3'b010;
    bus_if.a_bus = 12'hFFF;
    bus_if.b_bus = 12'hFFF;
    @(posedge clk); #1;
    bus_if.req = 3'b000;
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(bus_if.rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst_n  = 1'b1;
    last_m = 2;
    cnt_m  = 0;
    do_txn(3'b011, 12'($urandom), 12'($urandom), 1);
    do_txn(3'b010, 12'($urandom), 12'($urandom), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
